engine_clause_queue: RTL and testbench
======================================

Name: engine_clause_queue

Overview:
- Per-engine input buffer directly downstream of Distribution_unit; one instance per BCP engine (NUM_ENGINE instances).
- Accepts the clause granted to this engine and produces the full indication that drives Distribution_unit full_in[i].
- Holds the broadcast chosen unit clause (UC) until the engine acknowledges it.
- Presents clauses to the engine over a valid/ready interface.

Parameters:
- DEPTH, 8, clause entries; power of two, >= 4.
- SKID, 2, free entries still available when full_out asserts; covers the grant-to-full round-trip latency of Distribution_unit.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high; clears all state on the rising clock edge while it is high.
- clause_in  in  cla_t  clause from Distribution_unit clause_out[i].
- grant_in  in  1  Distribution_unit grant_out[i]; clause_in is valid this cycle.
- full_out  out  1  to Distribution_unit full_in[i].
- uc_in  in  lit_t  Distribution_unit chosen_uc_out.
- uc_valid_in  in  1  Distribution_unit chosen_uc_valid_out.
- flush_in  in  1  discard all buffered clauses and the pending UC (new solve/backtrack).
- clause_out  out  cla_t  head clause to the engine.
- clause_valid_out  out  1  head clause is valid.
- clause_ready_in  in  1  engine consumes the head clause.
- uc_out  out  lit_t  pending unit clause.
- uc_valid_out  out  1  UC pending.
- uc_ack_in  in  1  engine has consumed the UC.
- count_out  out  $clog2(DEPTH)+1  current occupancy.
- overflow_err  out  1  sticky: a grant was dropped.
- uc_overrun_err  out  1  sticky: a UC was overwritten before ack.

Behaviour:
- Reset values: all outputs 0; FIFO pointers 0; stored UC 0.
- Storage: circular FIFO with wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH; separate count register, 0..DEPTH.
- Output is first-word-fall-through:
  - clause_out = mem[rd_ptr].
  - clause_valid_out = (count != 0), registered-derived; no combinational path from any input.
  - clause_out is don't-care when invalid; the bench must not check it then.
- Push: grant_in && count < DEPTH. Write at wr_ptr, then wr_ptr++.
- Pop: clause_valid_out && clause_ready_in. rd_ptr++.
- Simultaneous push and pop: count unchanged. Allowed at count == DEPTH, because the pop frees a slot in the same cycle.
- Push into a full queue: grant_in && count == DEPTH && no pop. The clause is dropped, pointers hold, overflow_err sets to 1 and stays set until reset or flush.
- full_out = (count >= DEPTH - SKID), decoded from the count register. Latency: one cycle after the push that reaches the threshold; deasserts one cycle after the pop that drops below it.
- Push-to-visible latency is 1 cycle: a clause granted in cycle N appears on clause_out in cycle N+1 if the queue was empty.
- UC register:
  - uc_valid_in captures uc_in next edge and sets uc_valid_out.
  - uc_ack_in with no new uc_valid_in clears uc_valid_out.
  - uc_valid_in and uc_ack_in in the same cycle: the new UC is loaded and uc_valid_out stays 1.
  - uc_valid_in while a UC is pending and not acked: overwrite and set uc_overrun_err, except when uc_in equals the stored literal. A repeated equal UC is idempotent and does not set the error; this matters because Distribution_unit may hold chosen_uc_valid high for several cycles.
- Flush:
  - flush_in clears pointers, count, uc_valid_out and both error flags on the next edge.
  - Flush has priority over push, pop, uc_valid_in and uc_ack_in in the same cycle; a grant in the flush cycle is discarded.
- Reset mid-operation: identical to flush plus stored data zeroed; takes effect on the next edge regardless of the other inputs.

Decomposition:
- Shared package:
  - lit_t: 11 bits, {sign, 10-bit index}; LIT_IDX_MAX = 1024.
  - cla_t: CLA_LENGTH = 3 lits.
  - NUM_ENGINE.
  - Default DEPTH and SKID constants.
- One natural sub-module: sync_fifo (parameterised on width/depth, FWFT, count output). engine_clause_queue wraps it with the full threshold, the UC register and the error flags.

Test Plan:
- Reset, then grant clauses 1,2,3 on consecutive cycles with clause_ready_in=0 -> count_out=3, clause_out=1, clause_valid_out=1, full_out=0.
- Push 6 clauses into DEPTH=8 -> full_out rises the cycle after the 6th push. Two more grants -> count=8, overflow_err=0. A ninth grant -> dropped, overflow_err=1, count stays 8.
- At count=8, grant clause 24 and hold clause_ready_in=1 in the same cycle -> count stays 8, the head advances, and 24 emerges last in order.
- Drain with clause_ready_in held 1 -> all clauses emerge in push order, one per cycle, with no bubbles. clause_valid_out falls the cycle after the last pop; full_out falls once count < 6.
- uc_valid_in=1 with uc_in=11'b101_1011_1011 held 3 cycles, no ack -> uc_out=that literal, uc_valid_out=1, uc_overrun_err=0. A different uc_in before ack -> uc_overrun_err=1. A new uc_valid_in together with uc_ack_in -> uc_valid_out stays 1 with the new value.
- With 5 clauses queued and a UC pending, assert flush_in and grant_in together -> next cycle count=0, uc_valid_out=0, errors 0, clause_valid_out=0. Repeat with reset -> same result, and uc_out=0.

Source files
------------

// File: rtl/engine_clause_queue_pkg.sv
// Shared types and sizing constants for the per-engine clause queue.
// A literal is {sign, 10-bit index}; a clause is CLA_LENGTH literals.
package engine_clause_queue_pkg;

   localparam int LIT_IDX_W   = 10;
   localparam int LIT_IDX_MAX = 1024;
   localparam int LIT_W       = LIT_IDX_W + 1;
   localparam int CLA_LENGTH  = 3;
   localparam int NUM_ENGINE  = 4;
   localparam int DEF_DEPTH   = 8;
   localparam int DEF_SKID    = 2;

   typedef logic [LIT_W-1:0] lit_t;
   typedef lit_t [CLA_LENGTH-1:0] cla_t;

   localparam int CLA_W = $bits(cla_t);

   function automatic lit_t make_lit(input logic sign, input logic [LIT_IDX_W-1:0] idx);
      return {sign, idx};
   endfunction

endpackage

// File: rtl/engine_clause_queue_if.sv
// Bundle between Distribution_unit / BCP engine (master) and one clause queue (slave).
interface engine_clause_queue_if
   import engine_clause_queue_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) ();

   localparam int CNT_W = $clog2(DEPTH) + 1;

   cla_t             clause_in;
   logic             grant_in;
   logic             full_out;
   lit_t             uc_in;
   logic             uc_valid_in;
   logic             flush_in;
   cla_t             clause_out;
   logic             clause_valid_out;
   logic             clause_ready_in;
   lit_t             uc_out;
   logic             uc_valid_out;
   logic             uc_ack_in;
   logic [CNT_W-1:0] count_out;
   logic             overflow_err;
   logic             uc_overrun_err;

   modport slave (
      input  clause_in, grant_in, uc_in, uc_valid_in, flush_in,
             clause_ready_in, uc_ack_in,
      output full_out, clause_out, clause_valid_out, uc_out, uc_valid_out,
             count_out, overflow_err, uc_overrun_err
   );

   modport master (
      output clause_in, grant_in, uc_in, uc_valid_in, flush_in,
             clause_ready_in, uc_ack_in,
      input  full_out, clause_out, clause_valid_out, uc_out, uc_valid_out,
             count_out, overflow_err, uc_overrun_err
   );

endinterface

// File: rtl/engine_clause_queue_sync_fifo.sv
// First-word-fall-through circular FIFO with explicit occupancy register.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module engine_clause_queue_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       valid,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_acc;
   logic             pop_acc;

   assign valid    = (count_q != '0);
   assign full     = (count_q == CNT_W'(DEPTH));
   assign rdata    = mem_q[rd_ptr_q];
   assign count    = count_q;
   assign pop_acc  = pop && valid;
   assign push_acc = push && (!full || pop_acc);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_acc) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/engine_clause_queue.sv
// Per-engine input buffer: clause FIFO with early-full threshold, pending unit-clause
// register, and sticky overflow / UC-overrun flags.
module engine_clause_queue
   import engine_clause_queue_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int SKID  = DEF_SKID
) (
   input  logic                  clock,
   input  logic                  reset,
   engine_clause_queue_if.slave  q_if
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [CLA_W-1:0] fifo_rdata;
   logic             fifo_valid;
   logic             fifo_full;
   logic [CNT_W-1:0] fifo_count;
   logic             drop;

   lit_t uc_q, uc_d;
   logic uc_valid_q, uc_valid_d;
   logic overflow_q, overflow_d;
   logic overrun_q, overrun_d;

   engine_clause_queue_sync_fifo #(
      .WIDTH (CLA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .flush (q_if.flush_in),
      .push  (q_if.grant_in),
      .pop   (q_if.clause_ready_in),
      .wdata (q_if.clause_in),
      .rdata (fifo_rdata),
      .valid (fifo_valid),
      .full  (fifo_full),
      .count (fifo_count)
   );

   // When full the head is always valid, so a ready engine frees the slot this grant needs.
   assign drop = q_if.grant_in && fifo_full && !q_if.clause_ready_in;

   always_comb begin
      uc_d       = uc_q;
      uc_valid_d = uc_valid_q;
      overflow_d = overflow_q;
      overrun_d  = overrun_q;
      if (q_if.flush_in) begin
         uc_valid_d = 1'b0;
         overflow_d = 1'b0;
         overrun_d  = 1'b0;
      end else begin
         if (drop) begin
            overflow_d = 1'b1;
         end
         if (q_if.uc_valid_in) begin
            // Distribution_unit may hold the same UC for several cycles; only a different literal is an overrun.
            if (uc_valid_q && !q_if.uc_ack_in && (q_if.uc_in != uc_q)) begin
               overrun_d = 1'b1;
            end
            uc_d       = q_if.uc_in;
            uc_valid_d = 1'b1;
         end else if (q_if.uc_ack_in) begin
            uc_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         uc_q       <= '0;
         uc_valid_q <= 1'b0;
         overflow_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         uc_q       <= uc_d;
         uc_valid_q <= uc_valid_d;
         overflow_q <= overflow_d;
         overrun_q  <= overrun_d;
      end
   end

   assign q_if.clause_out       = fifo_rdata;
   assign q_if.clause_valid_out = fifo_valid;
   assign q_if.count_out        = fifo_count;
   assign q_if.full_out         = (fifo_count >= CNT_W'(DEPTH - SKID));
   assign q_if.uc_out           = uc_q;
   assign q_if.uc_valid_out     = uc_valid_q;
   assign q_if.overflow_err     = overflow_q;
   assign q_if.uc_overrun_err   = overrun_q;

endmodule

// File: tb/tb_engine_clause_queue.sv
// Directed bench for engine_clause_queue: queue-level reference model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_engine_clause_queue;
   import engine_clause_queue_pkg::*;

   localparam int DEPTH = 8;
   localparam int SKID  = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   bit   chk_en = 1'b0;

   always #5 clock = ~clock;

   engine_clause_queue_if #(.DEPTH(DEPTH)) q_if ();

   engine_clause_queue #(.DEPTH(DEPTH), .SKID(SKID)) dut (
      .clock (clock),
      .reset (reset),
      .q_if  (q_if.slave)
   );

   // reference model state
   cla_t m_q[$];
   lit_t m_uc;
   bit   m_ucv, m_ovf, m_ovr;

   function automatic cla_t mk_cla(input int n);
      cla_t c;
      c[0] = lit_t'(n);
      c[1] = lit_t'(n + 100);
      c[2] = lit_t'(n + 200);
      return c;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clock) begin
      if (reset) begin
         m_q.delete();
         m_uc = '0; m_ucv = 0; m_ovf = 0; m_ovr = 0;
      end else if (q_if.flush_in) begin
         m_q.delete();
         m_ucv = 0; m_ovf = 0; m_ovr = 0;
      end else begin
         if (m_q.size() != 0 && q_if.clause_ready_in) void'(m_q.pop_front());
         if (q_if.grant_in) begin
            if (m_q.size() < DEPTH) m_q.push_back(q_if.clause_in);
            else m_ovf = 1;
         end
         if (q_if.uc_valid_in) begin
            if (m_ucv && !q_if.uc_ack_in && q_if.uc_in != m_uc) m_ovr = 1;
            m_uc  = q_if.uc_in;
            m_ucv = 1;
         end else if (q_if.uc_ack_in) begin
            m_ucv = 0;
         end
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         chk("m_count", 64'(q_if.count_out), 64'(m_q.size()));
         chk("m_valid", 64'(q_if.clause_valid_out), 64'(m_q.size() != 0));
         if (m_q.size() != 0) chk("m_head", 64'(q_if.clause_out), 64'(m_q[0]));
         chk("m_full", 64'(q_if.full_out), 64'(m_q.size() >= DEPTH - SKID));
         chk("m_uc", 64'(q_if.uc_out), 64'(m_uc));
         chk("m_ucv", 64'(q_if.uc_valid_out), 64'(m_ucv));
         chk("m_ovf", 64'(q_if.overflow_err), 64'(m_ovf));
         chk("m_ovr", 64'(q_if.uc_overrun_err), 64'(m_ovr));
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      q_if.grant_in = 0; q_if.clause_in = '0; q_if.uc_valid_in = 0; q_if.uc_in = '0;
      q_if.flush_in = 0; q_if.clause_ready_in = 0; q_if.uc_ack_in = 0;
   endtask

   task automatic push_n(input int first, input int n);
      for (int i = 0; i < n; i++) begin
         q_if.grant_in = 1; q_if.clause_in = mk_cla(first + i);
         step();
      end
      q_if.grant_in = 0;
   endtask

   initial begin
      int exp_order[8];
      idle_inputs();
      reset = 1;
      step();
      chk_en = 1;
      step();
      reset = 0;
      chk("rst_count", 64'(q_if.count_out), 64'd0);
      chk("rst_valid", 64'(q_if.clause_valid_out), 64'd0);
      chk("rst_full", 64'(q_if.full_out), 64'd0);
      chk("rst_uc", 64'(q_if.uc_out), 64'd0);
      chk("rst_ovf", 64'(q_if.overflow_err), 64'd0);

      // three grants, engine not ready
      push_n(1, 3);
      chk("t1_count", 64'(q_if.count_out), 64'd3);
      chk("t1_head", 64'(q_if.clause_out), 64'(mk_cla(1)));
      chk("t1_valid", 64'(q_if.clause_valid_out), 64'd1);
      chk("t1_full", 64'(q_if.full_out), 64'd0);

      // fill to threshold, then to capacity, then overflow
      push_n(4, 2);
      chk("t2_full_at5", 64'(q_if.full_out), 64'd0);
      push_n(6, 1);
      chk("t2_full_at6", 64'(q_if.full_out), 64'd1);
      push_n(7, 2);
      chk("t2_count8", 64'(q_if.count_out), 64'd8);
      chk("t2_ovf0", 64'(q_if.overflow_err), 64'd0);
      push_n(9, 1);
      chk("t2_ovf1", 64'(q_if.overflow_err), 64'd1);
      chk("t2_count_hold", 64'(q_if.count_out), 64'd8);

      // push and pop together while full
      q_if.grant_in = 1; q_if.clause_in = mk_cla(24); q_if.clause_ready_in = 1;
      step();
      q_if.grant_in = 0; q_if.clause_ready_in = 0;
      chk("t3_count", 64'(q_if.count_out), 64'd8);
      chk("t3_head", 64'(q_if.clause_out), 64'(mk_cla(2)));
      chk("t3_ovf_sticky", 64'(q_if.overflow_err), 64'd1);

      // drain without bubbles
      exp_order = '{2, 3, 4, 5, 6, 7, 8, 24};
      q_if.clause_ready_in = 1;
      for (int i = 0; i < 8; i++) begin
         chk("t4_valid", 64'(q_if.clause_valid_out), 64'd1);
         chk("t4_order", 64'(q_if.clause_out), 64'(mk_cla(exp_order[i])));
         step();
      end
      q_if.clause_ready_in = 0;
      chk("t4_empty", 64'(q_if.clause_valid_out), 64'd0);
      chk("t4_full", 64'(q_if.full_out), 64'd0);

      // UC held, overwritten, reloaded with ack
      q_if.uc_valid_in = 1; q_if.uc_in = 11'b101_1011_1011;
      repeat (3) step();
      chk("t5_uc", 64'(q_if.uc_out), 64'h5BB);
      chk("t5_ucv", 64'(q_if.uc_valid_out), 64'd1);
      chk("t5_ovr0", 64'(q_if.uc_overrun_err), 64'd0);
      q_if.uc_in = 11'h00F;
      step();
      chk("t5_ovr1", 64'(q_if.uc_overrun_err), 64'd1);
      q_if.uc_in = 11'h055; q_if.uc_ack_in = 1;
      step();
      chk("t5_reload_v", 64'(q_if.uc_valid_out), 64'd1);
      chk("t5_reload_uc", 64'(q_if.uc_out), 64'h055);
      q_if.uc_valid_in = 0;
      step();
      q_if.uc_ack_in = 0;
      chk("t5_ack", 64'(q_if.uc_valid_out), 64'd0);

      // flush with grant and UC traffic in the same cycle
      push_n(31, 5);
      q_if.uc_valid_in = 1; q_if.uc_in = 11'h077;
      step();
      q_if.flush_in = 1; q_if.grant_in = 1; q_if.clause_in = mk_cla(99);
      q_if.uc_in = 11'h1FF; q_if.uc_ack_in = 1; q_if.clause_ready_in = 1;
      step();
      idle_inputs();
      chk("t6_count", 64'(q_if.count_out), 64'd0);
      chk("t6_valid", 64'(q_if.clause_valid_out), 64'd0);
      chk("t6_ucv", 64'(q_if.uc_valid_out), 64'd0);
      chk("t6_ovf", 64'(q_if.overflow_err), 64'd0);
      chk("t6_ovr", 64'(q_if.uc_overrun_err), 64'd0);
      step();
      chk("t6_no_late", 64'(q_if.count_out), 64'd0);

      // reset mid-operation
      push_n(41, 5);
      q_if.uc_valid_in = 1; q_if.uc_in = 11'h011;
      step();
      q_if.uc_in = 11'h022;
      step();
      chk("t7_ovr_pre", 64'(q_if.uc_overrun_err), 64'd1);
      reset = 1; q_if.grant_in = 1; q_if.clause_in = mk_cla(77);
      step();
      reset = 0;
      idle_inputs();
      chk("t7_count", 64'(q_if.count_out), 64'd0);
      chk("t7_valid", 64'(q_if.clause_valid_out), 64'd0);
      chk("t7_ucv", 64'(q_if.uc_valid_out), 64'd0);
      chk("t7_uc", 64'(q_if.uc_out), 64'd0);
      chk("t7_ovr", 64'(q_if.uc_overrun_err), 64'd0);
      chk("t7_ovf", 64'(q_if.overflow_err), 64'd0);
      repeat (2) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
